// File: rtl/aes_sub_bytes_ctrl.sv
// Control peer of the masked SubBytes stage: sequences PRD refresh, Sp2V enable/ack
// handshaking and done signalling, and latches any protocol fault into a terminal alert.
module aes_sub_bytes_ctrl #(
   parameter int unsigned PrdRefreshEvery = 1,
   parameter int unsigned TimeoutCycles   = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   output logic       start_ready_o,
   output logic       done_o,
   output logic       prd_req_o,
   input  logic       prd_ack_i,
   output logic [2:0] sb_en_o,
   output logic       sb_prd_we_o,
   input  logic [2:0] sb_out_req_i,
   output logic [2:0] sb_out_ack_o,
   input  logic       sb_err_i,
   output logic       alert_o
);

   localparam logic [2:0] SP2V_HIGH = 3'b011;
   localparam logic [2:0] SP2V_LOW  = 3'b100;

   localparam int unsigned RW = (PrdRefreshEvery > 1) ? $clog2(PrdRefreshEvery) : 1;
   localparam int unsigned TW = $clog2(TimeoutCycles);
   localparam logic [RW-1:0] REFRESH_MAX = RW'(PrdRefreshEvery - 1);
   localparam logic [TW-1:0] TMO_MAX     = TW'(TimeoutCycles - 1);

   // Pairwise Hamming distance >= 3 so a single upset never lands on another legal state.
   typedef enum logic [5:0] {
      ST_IDLE    = 6'b000000,
      ST_PRD_REQ = 6'b000111,
      ST_PRD_WE  = 6'b111000,
      ST_RUN     = 6'b011011,
      ST_ACK     = 6'b101101,
      ST_ERROR   = 6'b110110
   } state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [RW-1:0]   r_refresh_cnt;
   logic [TW-1:0]   r_tmo_cnt;
   logic            r_start_ready;
   logic            r_done;
   logic            r_prd_req;
   logic            r_prd_we;
   logic [2:0]      r_sb_en;
   logic [2:0]      r_sb_ack;
   logic            r_alert;

   logic            w_req_high;
   logic            w_req_low;

   assign w_req_high = (sb_out_req_i == SP2V_HIGH);
   assign w_req_low  = (sb_out_req_i == SP2V_LOW);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = (r_refresh_cnt == '0) ? ST_PRD_REQ : ST_RUN;
            end
         end
         ST_PRD_REQ: begin
            if (prd_ack_i) begin
               w_state_nxt = ST_PRD_WE;
            end
         end
         ST_PRD_WE: w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (w_req_high) begin
               w_state_nxt = ST_ACK;
            end else if (w_req_low && (r_tmo_cnt == TMO_MAX)) begin
               w_state_nxt = ST_ERROR;
            end
         end
         ST_ACK:   w_state_nxt = ST_IDLE;
         ST_ERROR: w_state_nxt = ST_ERROR;
         default:  w_state_nxt = ST_ERROR;
      endcase

      // Protocol checks apply in every state and override the normal flow.
      if (!w_req_high && !w_req_low) begin
         w_state_nxt = ST_ERROR;
      end
      if (w_req_high && (r_state != ST_RUN) && (r_state != ST_ACK)) begin
         w_state_nxt = ST_ERROR;
      end
      if (sb_err_i) begin
         w_state_nxt = ST_ERROR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_refresh_cnt <= '0;
         r_tmo_cnt     <= '0;
         r_start_ready <= 1'b1;
         r_done        <= 1'b0;
         r_prd_req     <= 1'b0;
         r_prd_we      <= 1'b0;
         r_sb_en       <= SP2V_LOW;
         r_sb_ack      <= SP2V_LOW;
         r_alert       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // Counter sits at zero outside RUN, so entering RUN always starts from zero.
         if (r_state == ST_RUN) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end else begin
            r_tmo_cnt <= '0;
         end

         if (r_state == ST_ACK) begin
            r_refresh_cnt <= (r_refresh_cnt == REFRESH_MAX) ? '0 : r_refresh_cnt + RW'(1);
         end

         r_start_ready <= (w_state_nxt == ST_IDLE);
         r_done        <= (w_state_nxt == ST_ACK);
         r_prd_req     <= (w_state_nxt == ST_PRD_REQ);
         r_prd_we      <= (w_state_nxt == ST_PRD_WE);
         r_sb_en       <= ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_ACK)) ? SP2V_HIGH : SP2V_LOW;
         r_sb_ack      <= (w_state_nxt == ST_ACK) ? SP2V_HIGH : SP2V_LOW;
         r_alert       <= (w_state_nxt == ST_ERROR);
      end
   end

   assign start_ready_o = r_start_ready;
   assign done_o        = r_done;
   assign prd_req_o     = r_prd_req;
   assign sb_prd_we_o   = r_prd_we;
   assign sb_en_o       = r_sb_en;
   assign sb_out_ack_o  = r_sb_ack;
   assign alert_o       = r_alert;

endmodule

// File: tb/tb_aes_sub_bytes_ctrl.sv
// Directed bench for aes_sub_bytes_ctrl: every cycle compares the full output vector
// against the expected state's output pattern.
module tb_aes_sub_bytes_ctrl;

   localparam logic [2:0] HIGH = 3'b011;
   localparam logic [2:0] LOW  = 3'b100;

   // {start_ready, done, prd_req, prd_we, en[2:0], ack[2:0], alert}
   localparam logic [10:0] V_IDLE   = 11'b1_0_0_0_100_100_0;
   localparam logic [10:0] V_PRDREQ = 11'b0_0_1_0_100_100_0;
   localparam logic [10:0] V_PRDWE  = 11'b0_0_0_1_100_100_0;
   localparam logic [10:0] V_RUN    = 11'b0_0_0_0_011_100_0;
   localparam logic [10:0] V_ACK    = 11'b0_1_0_0_011_011_0;
   localparam logic [10:0] V_ERR    = 11'b0_0_0_0_100_100_1;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       start_ready_o;
   logic       done_o;
   logic       prd_req_o;
   logic       prd_ack_i;
   logic [2:0] sb_en_o;
   logic       sb_prd_we_o;
   logic [2:0] sb_out_req_i;
   logic [2:0] sb_out_ack_o;
   logic       sb_err_i;
   logic       alert_o;
   logic [10:0] w_obs;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   assign w_obs = {start_ready_o, done_o, prd_req_o, sb_prd_we_o, sb_en_o, sb_out_ack_o, alert_o};

   aes_sub_bytes_ctrl #(
      .PrdRefreshEvery(3),
      .TimeoutCycles  (64)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .start_ready_o(start_ready_o),
      .done_o       (done_o),
      .prd_req_o    (prd_req_o),
      .prd_ack_i    (prd_ack_i),
      .sb_en_o      (sb_en_o),
      .sb_prd_we_o  (sb_prd_we_o),
      .sb_out_req_i (sb_out_req_i),
      .sb_out_ack_o (sb_out_ack_o),
      .sb_err_i     (sb_err_i),
      .alert_o      (alert_o)
   );

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_i        = 1'b1;
      start_i      = 1'b0;
      prd_ack_i    = 1'b0;
      sb_out_req_i = LOW;
      sb_err_i     = 1'b0;
      cyc();
      chk("reset", w_obs, V_IDLE);
      cyc();
      rst_i = 1'b0;
   endtask

   // One complete op; refr selects whether a PRD refresh phase is expected.
   task automatic do_op(input string tag, input bit refr, input int ack_wait, input int run_len);
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      if (refr) begin
         for (int i = 0; i < ack_wait; i++) begin
            chk({tag, "_prdreq"}, w_obs, V_PRDREQ);
            if (i == ack_wait - 1) prd_ack_i = 1'b1;
            cyc();
         end
         prd_ack_i = 1'b0;
         chk({tag, "_prdwe"}, w_obs, V_PRDWE);
         cyc();
      end
      for (int i = 0; i < run_len; i++) begin
         chk({tag, "_run"}, w_obs, V_RUN);
         if (i == run_len - 1) sb_out_req_i = HIGH;
         cyc();
      end
      chk({tag, "_ack"}, w_obs, V_ACK);
      cyc();
      sb_out_req_i = LOW;
      chk({tag, "_idle"}, w_obs, V_IDLE);
   endtask

   // From IDLE right after reset: refresh with immediate prd_ack, ends in first RUN cycle.
   task automatic to_run(input string tag);
      start_i = 1'b1;
      cyc();
      start_i   = 1'b0;
      prd_ack_i = 1'b1;
      chk({tag, "_prdreq"}, w_obs, V_PRDREQ);
      cyc();
      prd_ack_i = 1'b0;
      chk({tag, "_prdwe"}, w_obs, V_PRDWE);
      cyc();
   endtask

   initial begin
      do_reset();

      // start @0, prd_ack @3, out_req HIGH @8 -> ack/done @9, ready @10
      do_op("lat", 1'b1, 3, 4);

      // Refresh every 3 ops: ops 1 and 4 refresh, 2 and 3 go straight to RUN
      do_reset();
      do_op("b2b1", 1'b1, 2, 3);
      do_op("b2b2", 1'b0, 0, 2);
      do_op("b2b3", 1'b0, 0, 1);
      do_op("b2b4", 1'b1, 1, 2);

      // Timeout: 64 RUN cycles with out_req LOW, then alert; start ignored afterwards
      do_reset();
      to_run("tmo");
      for (int i = 0; i < 64; i++) begin
         chk("tmo_run", w_obs, V_RUN);
         cyc();
      end
      chk("tmo_err", w_obs, V_ERR);
      start_i = 1'b1;
      cyc();
      cyc();
      start_i = 1'b0;
      chk("tmo_sticky", w_obs, V_ERR);

      // Illegal out_req encoding during RUN
      do_reset();
      to_run("bad");
      sb_out_req_i = 3'b111;
      cyc();
      sb_out_req_i = LOW;
      chk("bad_err", w_obs, V_ERR);
      cyc();
      cyc();
      chk("bad_sticky", w_obs, V_ERR);

      // out_req HIGH while IDLE
      do_reset();
      sb_out_req_i = HIGH;
      cyc();
      sb_out_req_i = LOW;
      chk("idle_high_err", w_obs, V_ERR);
      cyc();
      chk("idle_high_sticky", w_obs, V_ERR);

      // sb_err in PRD_REQ, then reset recovers and first op refreshes
      do_reset();
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      chk("err_prdreq", w_obs, V_PRDREQ);
      sb_err_i = 1'b1;
      cyc();
      sb_err_i = 1'b0;
      chk("err_alert", w_obs, V_ERR);
      cyc();
      chk("err_sticky", w_obs, V_ERR);
      do_reset();
      do_op("err_rec", 1'b1, 1, 1);

      // Reset during RUN of a non-refresh op: no done, and next op refreshes again
      do_reset();
      do_op("rr1", 1'b1, 1, 1);
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      chk("rr2_run", w_obs, V_RUN);
      cyc();
      chk("rr2_run2", w_obs, V_RUN);
      rst_i = 1'b1;
      cyc();
      chk("rr_mid_rst", w_obs, V_IDLE);
      rst_i = 1'b0;
      cyc();
      chk("rr_after_rst", w_obs, V_IDLE);
      do_op("rr_post", 1'b1, 2, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
